// File: rtl/sym_serializer.sv
// Serializes a packed word of up to NSYM 2-bit symbols onto a one-symbol-per-clock stream,
// driving IDLE_SYM whenever no real symbol is being presented.
module sym_serializer #(
   parameter int         NSYM     = 8,
   parameter int         LW       = 4,
   parameter logic [1:0] IDLE_SYM = 2'b10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [2*NSYM-1:0] load_data,
   input  logic [LW-1:0]     load_len,
   input  logic              pause,
   output logic [1:0]        sym,
   output logic              sym_valid,
   output logic              last
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state, state_n;
   logic [2*NSYM-1:0] shift_reg, shift_reg_n;
   logic [LW-1:0]     rem, rem_n;
   logic [1:0]        sym_n;
   logic              sym_valid_n, last_n;
   logic              xfer;
   logic [LW-1:0]     eff_len;

   // A new word may be taken on the edge that retires the final symbol, giving zero-gap streams.
   assign load_ready = !reset && ((state == IDLE) || ((rem == LW'(1)) && !pause));
   assign xfer       = load_valid && load_ready;
   assign eff_len    = (load_len > LW'(NSYM)) ? LW'(NSYM) : load_len;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         rem       <= '0;
         sym       <= IDLE_SYM;
         sym_valid <= 1'b0;
         last      <= 1'b0;
      end else begin
         state     <= state_n;
         shift_reg <= shift_reg_n;
         rem       <= rem_n;
         sym       <= sym_n;
         sym_valid <= sym_valid_n;
         last      <= last_n;
      end
   end

   // shift_reg holds the symbols still waiting behind the one currently on sym.
   always_comb begin
      state_n     = state;
      shift_reg_n = shift_reg;
      rem_n       = rem;
      sym_n       = sym;
      sym_valid_n = sym_valid;
      last_n      = last;

      if ((state == SHIFT) && !pause) begin
         if (rem == LW'(1)) begin
            state_n     = IDLE;
            rem_n       = '0;
            sym_n       = IDLE_SYM;
            sym_valid_n = 1'b0;
            last_n      = 1'b0;
         end else begin
            sym_n       = shift_reg[1:0];
            shift_reg_n = shift_reg >> 2;
            rem_n       = rem - LW'(1);
            last_n      = (rem == LW'(2));
         end
      end

      // A zero-length word is accepted but leaves the (already idle-bound) state alone.
      if (xfer && (eff_len != '0)) begin
         state_n     = SHIFT;
         rem_n       = eff_len;
         sym_n       = load_data[1:0];
         shift_reg_n = load_data >> 2;
         sym_valid_n = 1'b1;
         last_n      = (eff_len == LW'(1));
      end
   end

endmodule

// File: tb/tb_sym_serializer.sv
// Directed, table-driven bench for sym_serializer: each record drives one cycle and states
// the expected load_ready before the edge and the registered outputs after it.
module tb_sym_serializer;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [3:0]  load_len;
   logic        pause;
   logic [1:0]  sym;
   logic        sym_valid;
   logic        last;

   int check_count = 0;
   int pass_count  = 0;
   int step_count  = 0;

   typedef struct {
      logic        rst;
      logic        lv;
      logic [15:0] ld;
      logic [3:0]  ll;
      logic        ps;
      logic        exp_ready;
      logic [1:0]  exp_sym;
      logic        exp_valid;
      logic        exp_last;
   } vec_t;

   vec_t vecs[$];

   sym_serializer #(.NSYM(8), .LW(4), .IDLE_SYM(2'b10)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .pause      (pause),
      .sym        (sym),
      .sym_valid  (sym_valid),
      .last       (last)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, step_count, act, exp);
   endtask

   // Drive inputs mid-cycle, check the combinational ready, then check registered outputs after the edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clock);
      reset      = v.rst;
      load_valid = v.lv;
      load_data  = v.ld;
      load_len   = v.ll;
      pause      = v.ps;
      #1;
      checkOutput("load_ready", {1'b0, load_ready}, {1'b0, v.exp_ready});
      @(posedge clock);
      #1;
      checkOutput("sym", sym, v.exp_sym);
      checkOutput("sym_valid", {1'b0, sym_valid}, {1'b0, v.exp_valid});
      checkOutput("last", {1'b0, last}, {1'b0, v.exp_last});
      step_count++;
   endtask

   task automatic step(input logic rst, input logic lv, input logic [15:0] ld, input logic [3:0] ll,
                       input logic ps, input logic er, input logic [1:0] es, input logic ev,
                       input logic el);
      vec_t v;
      v = '{rst, lv, ld, ll, ps, er, es, ev, el};
      applyStimulus(v);
   endtask

   task automatic addVec(input logic rst, input logic lv, input logic [15:0] ld, input logic [3:0] ll,
                         input logic ps, input logic er, input logic [1:0] es, input logic ev,
                         input logic el);
      vecs.push_back('{rst, lv, ld, ll, ps, er, es, ev, el});
   endtask

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_data = '0; load_len = '0; pause = 1'b0;

      // Single ABBC word after two reset cycles.
      addVec(1, 0, 16'h0000, 0, 0, 0, 2, 0, 0);
      addVec(1, 0, 16'h0000, 0, 0, 0, 2, 0, 0);
      addVec(0, 1, 16'h00D4, 4, 0, 1, 0, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 3, 1, 1);
      addVec(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0);
      // Back-to-back: second word held valid, taken on the first word's final edge.
      addVec(0, 1, 16'h00D4, 4, 0, 1, 0, 1, 0);
      addVec(0, 1, 16'h0007, 2, 0, 0, 1, 1, 0);
      addVec(0, 1, 16'h0007, 2, 0, 0, 1, 1, 0);
      addVec(0, 1, 16'h0007, 2, 0, 0, 3, 1, 1);
      addVec(0, 1, 16'h0007, 2, 0, 1, 3, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 1, 1, 1);
      addVec(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0);
      // Zero length is swallowed; length 15 clamps to 8; zero length on the final edge leads to idle.
      addVec(0, 1, 16'hABCD, 0, 0, 1, 2, 0, 0);
      addVec(0, 1, 16'hFFFF, 15, 0, 1, 3, 1, 0);
      for (int i = 0; i < 6; i++) addVec(0, 0, 16'h0000, 0, 0, 0, 3, 1, 0);
      addVec(0, 0, 16'h0000, 0, 0, 0, 3, 1, 1);
      addVec(0, 1, 16'h5555, 0, 0, 1, 2, 0, 0);
      addVec(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0);
      // Pause is ignored in idle; pause on a single-symbol word holds last and blocks ready.
      addVec(0, 1, 16'h0001, 1, 1, 1, 1, 1, 1);
      addVec(0, 0, 16'h0000, 0, 1, 0, 1, 1, 1);
      addVec(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Pause three cycles while symbol 1 is showing.
      step(1, 0, 16'h0000, 0, 0, 0, 2, 0, 0);
      step(0, 1, 16'h00D4, 4, 0, 1, 0, 1, 0);
      step(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 0, 1, 0, 1, 1, 0);
      step(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0);
      step(0, 0, 16'h0000, 0, 0, 0, 3, 1, 1);
      step(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0);

      // Reset while symbol 2 is showing, with a competing load that must be refused.
      step(0, 1, 16'h00D4, 4, 0, 1, 0, 1, 0);
      step(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0);
      step(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0);
      step(1, 1, 16'h0003, 1, 0, 0, 2, 0, 0);
      step(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0);
      step(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0);
      step(0, 1, 16'h0001, 1, 0, 1, 1, 1, 1);
      step(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
